// File: rtl/complex_mult_arbiter_if.sv
// complex_mult_arbiter_if: requester-side and multiplier-side buses of the complex multiplier arbiter
interface complex_mult_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH = 2*DATA_WIDTH+1
);
  logic [1:0]              s_op_val;
  logic [1:0]              s_op_ready;
  logic [8*DATA_WIDTH-1:0] s_op_data;
  logic [1:0]              s_res_val;
  logic [1:0]              s_res_ready;
  logic [RES_WIDTH-1:0]    s_res_re;
  logic [RES_WIDTH-1:0]    s_res_im;
  logic                    s_err;
  logic                    m_op_val;
  logic                    m_op_ready;
  logic [4*DATA_WIDTH-1:0] m_op_data;
  logic                    m_res_val;
  logic                    m_res_ready;
  logic [RES_WIDTH-1:0]    m_res_re;
  logic [RES_WIDTH-1:0]    m_res_im;
  logic                    m_sw_rst;
  modport slave (
    input  s_op_val, s_op_data, s_res_ready, m_op_ready, m_res_val, m_res_re, m_res_im,
    output s_op_ready, s_res_val, s_res_re, s_res_im, s_err, m_op_val, m_op_data, m_res_ready, m_sw_rst
  );
  modport master (
    output s_op_val, s_op_data, s_res_ready, m_op_ready, m_res_val, m_res_re, m_res_im,
    input  s_op_ready, s_res_val, s_res_re, s_res_im, s_err, m_op_val, m_op_data, m_res_ready, m_sw_rst
  );
endinterface

// File: rtl/complex_mult_arbiter.sv
// complex_mult_arbiter: round-robin sharing of one complex multiplier between two requesters.
// Optional watchdog abort on a stuck multiplier enabled by defining CMA_TIMEOUT_EN.
module complex_mult_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH = 2*DATA_WIDTH+1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rstn,
  complex_mult_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_RES = 2'd2, DELIVER = 2'd3;
  localparam int OW = 4*DATA_WIDTH;
  logic [1:0] state;
  logic grant, last, pick, tmo;
  logic [OW-1:0] ops;
  logic [RES_WIDTH-1:0] res_re, res_im;
  // on a tie the requester not served last wins
  assign pick = (&bus.s_op_val) ? ~last : bus.s_op_val[1];
  assign bus.m_op_val = state == ISSUE;
  assign bus.m_res_ready = state == WAIT_RES;
  assign bus.s_res_val = state == DELIVER ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.m_op_data = ops;
  assign bus.s_res_re = res_re;
  assign bus.s_res_im = res_im;
`ifdef CMA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;
  logic err, sw_rst;
  assign tmo = state == WAIT_RES && !bus.m_res_val && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign bus.s_err = err;
  assign bus.m_sw_rst = sw_rst;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= '0;
      err <= 1'b0;
      sw_rst <= 1'b0;
    end else begin
      cnt <= state == WAIT_RES ? cnt + 1'b1 : '0;
      sw_rst <= tmo;
      err <= state == WAIT_RES ? tmo : err;
    end
`else
  // a limit that can never be reached keeps the watchdog out of this build
  assign tmo = TIMEOUT_CYCLES < 0;
  assign bus.s_err = 1'b0;
  assign bus.m_sw_rst = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      grant <= 1'b0;
      last <= 1'b1;
      ops <= '0;
      res_re <= '0;
      res_im <= '0;
      bus.s_op_ready <= 2'b00;
    end else begin
      bus.s_op_ready <= 2'b00;
      case (state)
        IDLE: if (|bus.s_op_val) begin
          grant <= pick;
          ops <= pick ? bus.s_op_data[OW +: OW] : bus.s_op_data[0 +: OW];
          bus.s_op_ready <= pick ? 2'b10 : 2'b01;
          state <= ISSUE;
        end
        ISSUE: if (bus.m_op_ready) state <= WAIT_RES;
        WAIT_RES: if (bus.m_res_val) begin
          res_re <= bus.m_res_re;
          res_im <= bus.m_res_im;
          state <= DELIVER;
        end else if (tmo) begin
          res_re <= '0;
          res_im <= '0;
          state <= DELIVER;
        end
        default: if (bus.s_res_ready[grant]) begin
          last <= grant;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: doc/complex_mult_arbiter.md
COMPLEX_MULT_ARBITER -- requirements
Module: complex_mult_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand component width.
REQ-002 Parameter RES_WIDTH, default 2*DATA_WIDTH+1, result component width.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, watchdog limit (used only with CMA_TIMEOUT_EN).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rstn  input  1  asynchronous reset, active low.
REQ-006 s_op_val  input  2  per-requester operand valid.
REQ-007 s_op_ready  output  2  per-requester operand accepted pulse.
REQ-008 s_op_data  input  8*DATA_WIDTH  requester i at slice [4*DW*i +: 4*DW], fields {op_2_im, op_2_re, op_1_im, op_1_re}, op_1_re at LSB.
REQ-009 s_res_val  output  2  per-requester result valid.
REQ-010 s_res_ready  input  2  per-requester result consumed.
REQ-011 s_res_re, s_res_im  output  RES_WIDTH each  shared result bus, meaningful only under s_res_val.
REQ-012 s_err  output  1  result is a timeout abort, qualified by s_res_val.
REQ-013 m_op_val  output  1  operand valid to multiplier.
REQ-014 m_op_ready  input  1  multiplier accepts operands.
REQ-015 m_op_data  output  4*DATA_WIDTH  granted operands, same field order as REQ-008.
REQ-016 m_res_val  input  1  multiplier result valid.
REQ-017 m_res_ready  output  1  arbiter consumes result.
REQ-018 m_res_re, m_res_im  input  RES_WIDTH each  multiplier result.
REQ-019 m_sw_rst  output  1  software reset to multiplier, active high.

Function
REQ-020 Single outstanding transaction; FSM states IDLE, ISSUE, WAIT_RES, DELIVER.
REQ-021 IDLE: any s_op_val high -> grant chosen, s_op_data slice latched, s_op_ready[grant] high exactly one cycle, next state ISSUE.
REQ-022 Arbitration round-robin: both requesting -> requester not granted last wins; one requesting -> it wins.
REQ-023 ISSUE: m_op_val=1, m_op_data=latched operands, held stable until clock edge with m_op_ready=1, then WAIT_RES; m_op_val 0 next cycle.
REQ-024 WAIT_RES: m_res_ready=1; on edge with m_res_val=1, latch m_res_re/m_res_im, s_err=0, go DELIVER.
REQ-025 DELIVER: s_res_val[grant]=1 only, result stable; on edge with s_res_ready[grant]=1 -> IDLE, last-grant updated; s_res_ready of other bit ignored.
REQ-026 Minimum latency s_op_val to m_op_val: 1 cycle; back-to-back: new grant possible in the IDLE cycle following DELIVER.
REQ-027 s_op_val changes outside IDLE ignored; operands sampled only at grant.
REQ-028 m_res_val outside WAIT_RES ignored; m_op_ready outside ISSUE ignored.
REQ-029 Data path widths pass-through; no arithmetic, truncation or sign extension.

Reset
REQ-030 rstn low: state IDLE, all outputs 0, latched data 0, last-grant=1 (requester 0 wins first tie), watchdog counter 0.
REQ-031 Reset mid-transaction abandons it; no s_res_val issued for it.

Configuration
REQ-032 Macro CMA_TIMEOUT_EN defined: counter runs in WAIT_RES, cleared on entry; reaching TIMEOUT_CYCLES without m_res_val -> m_sw_rst=1 one cycle, go DELIVER with s_err=1, s_res_re/s_res_im=0.
REQ-033 CMA_TIMEOUT_EN undefined: no counter, WAIT_RES waits indefinitely, m_sw_rst and s_err tied 0.

Verification
REQ-034 Req0 only, ops (2,4)x(3,6), multiplier returns (-18,24) -> m_op_data carries operands, s_res_val=01, s_res_re=-18, s_res_im=24, s_err=0.
REQ-035 Both requesters valid from reset -> grants order 0,1,0,1 over four transactions; s_op_ready pulses one cycle each.
REQ-036 m_op_ready delayed 5 cycles -> m_op_val and m_op_data stable all 5 cycles, one handshake only.
REQ-037 s_res_ready[grant] held 0 for 10 cycles -> result held, no new grant, no second s_op_ready.
REQ-038 rstn low during WAIT_RES -> all outputs 0 next cycle, stray m_res_val after release ignored.
REQ-039 With CMA_TIMEOUT_EN, TIMEOUT_CYCLES=8, no m_res_val -> m_sw_rst pulse after 8 cycles, s_err=1, zero result delivered.
